// File: rtl/opb_master_rr_arbiter_if.sv
// Bus bundle between the OPB masters and the round-robin arbiter/watchdog.
// "master" is the requesting side; "slave" is the arbiter's view of the same wires.
interface opb_master_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  logic [NUM_MASTERS-1:0] M_request;
  logic [NUM_MASTERS-1:0] M_busLock;
  logic [NUM_MASTERS-1:0] M_select;
  logic                   OPB_xferAck;
  logic                   OPB_errAck;
  logic                   OPB_retry;
  logic                   OPB_toutSup;
  logic [NUM_MASTERS-1:0] OPB_MGrant;
  logic                   OPB_select;
  logic                   OPB_timeout;
  logic [2:0]             arb_owner;

  modport master (
    output M_request, M_busLock, M_select,
    output OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
    input  OPB_MGrant, OPB_select, OPB_timeout, arb_owner
  );

  modport slave (
    input  M_request, M_busLock, M_select,
    input  OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
    output OPB_MGrant, OPB_select, OPB_timeout, arb_owner
  );
endinterface

// File: rtl/opb_master_rr_arbiter.sv
// Round-robin OPB arbiter with bus-lock support and a no-response watchdog.
// Define OPB_ARB_PARK_EN to park the grant on the last owner while the bus is idle.
module opb_master_rr_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          OPB_Clk,
  input  logic                          OPB_Rst,
  opb_master_rr_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  localparam logic [2:0] LAST_AT_RESET = 3'(NUM_MASTERS - 1);
  localparam logic [7:0] LIMIT         = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] NM4           = 4'(NUM_MASTERS);

  state_t                 state;
  logic [2:0]             last_owner;
  logic [NUM_MASTERS-1:0] grant;
  logic                   timeout;
  logic [7:0]             count;

  logic [2:0]             winner;
  logic [3:0]             cand;
  logic [NUM_MASTERS-1:0] owner_mask;
  logic                   owner_sel;
  logic                   owner_req;
  logic                   owner_lock;
  logic                   any_request;
  logic                   response;

  function automatic logic [NUM_MASTERS-1:0] one_hot(input logic [2:0] idx);
    one_hot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Scan downward so the last hit is the nearest requester after last_owner.
  always_comb begin
    winner = last_owner;
    cand   = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = {1'b0, last_owner} + 4'(i);
      if (cand >= NM4) cand = cand - NM4;
      if (|(bus.M_request & one_hot(cand[2:0]))) winner = cand[2:0];
    end
  end

  assign owner_mask  = one_hot(last_owner);
  assign owner_sel   = |(bus.M_select  & owner_mask);
  assign owner_req   = |(bus.M_request & owner_mask);
  assign owner_lock  = |(bus.M_busLock & owner_mask);
  assign any_request = |bus.M_request;
  assign response    = bus.OPB_xferAck | bus.OPB_errAck | bus.OPB_retry | bus.OPB_toutSup;

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state      <= IDLE;
      last_owner <= LAST_AT_RESET;
      grant      <= '0;
      timeout    <= 1'b0;
      count      <= '0;
    end else begin
      timeout <= 1'b0;
      count   <= '0;
      case (state)
        IDLE: begin
`ifdef OPB_ARB_PARK_EN
          if (owner_sel && |(grant & owner_mask)) begin
            state <= BUSY;
            grant <= '0;
          end else if (any_request) begin
            last_owner <= winner;
            grant      <= one_hot(winner);
            state      <= GRANT;
          end else begin
            grant <= owner_mask;
          end
`else
          if (any_request) begin
            last_owner <= winner;
            grant      <= one_hot(winner);
            state      <= GRANT;
          end else begin
            grant <= '0;
          end
`endif
        end
        GRANT: begin
          if (owner_sel) begin
            state <= BUSY;
            grant <= '0;
          end else if (!owner_req && !owner_lock) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        BUSY: begin
          if (!owner_sel) begin
            if (owner_lock) begin
              state <= GRANT;
              grant <= owner_mask;
            end else begin
              state <= IDLE;
            end
          end
          // Fire on the edge whose increment would land on LIMIT; a response wins.
          if (bus.OPB_select && !response) begin
            if (count == LIMIT - 8'd1) timeout <= 1'b1;
            else                       count   <= count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.OPB_MGrant  = grant;
  assign bus.OPB_select  = |bus.M_select;
  assign bus.OPB_timeout = timeout;
  assign bus.arb_owner   = last_owner;

endmodule

// File: tb/tb_opb_master_rr_arbiter.sv
// Directed bench for opb_master_rr_arbiter with 4 masters and a 16-cycle watchdog.
// Expectations follow OPB_ARB_PARK_EN when the bench is built with it.
module tb_opb_master_rr_arbiter;

  localparam int NM = 4;
  localparam int TO = 16;
`ifdef OPB_ARB_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic clk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   pulses;
  int   first;

  opb_master_rr_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  opb_master_rr_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
    .OPB_Clk (clk),
    .OPB_Rst (rst),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // resp = {toutSup, retry, errAck, xferAck}
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock,
                               input logic [3:0] sel, input logic [3:0] resp);
    bus.M_request   = req;
    bus.M_busLock   = lock;
    bus.M_select    = sel;
    bus.OPB_xferAck = resp[0];
    bus.OPB_errAck  = resp[1];
    bus.OPB_retry   = resp[2];
    bus.OPB_toutSup = resp[3];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, optionally acking at cycle ack_at, and tally timeout pulses.
  task automatic count_pulses(input int n, input int ack_at, output int np, output int fp);
    np = 0;
    fp = 0;
    for (int k = 1; k <= n; k++) begin
      bus.OPB_xferAck = (k == ack_at);
      tick();
      if (bus.OPB_timeout) begin
        np++;
        if (fp == 0) fp = k;
      end
    end
    bus.OPB_xferAck = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_grant",   32'(bus.OPB_MGrant),  32'h0);
    checkOutput("reset_timeout", 32'(bus.OPB_timeout), 32'h0);
    checkOutput("reset_owner",   32'(bus.arb_owner),   32'h3);
    checkOutput("reset_select",  32'(bus.OPB_select),  32'h0);
    rst = 1'b0;

    // single master transfer acknowledged every cycle
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("t1_grant", 32'(bus.OPB_MGrant), 32'h1);
    checkOutput("t1_owner", 32'(bus.arb_owner),  32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0001);
    #1;
    checkOutput("t1_select_comb", 32'(bus.OPB_select), 32'h1);
    tick();
    checkOutput("t1_grant_drop", 32'(bus.OPB_MGrant),  32'h0);
    checkOutput("t1_timeout0",   32'(bus.OPB_timeout), 32'h0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput($sformatf("t1_timeout%0d", c + 1), 32'(bus.OPB_timeout), 32'h0);
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("t1_idle", 32'(bus.OPB_MGrant), 32'h0);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("t1_regrant",  32'(bus.OPB_MGrant), 32'h2);
    checkOutput("t1_owner1",   32'(bus.arb_owner),  32'h1);

    // asynchronous reset while a grant is held
    #2 rst = 1'b1;
    #1;
    checkOutput("rstA_grant",   32'(bus.OPB_MGrant),  32'h0);
    checkOutput("rstA_owner",   32'(bus.arb_owner),   32'h3);
    checkOutput("rstA_timeout", 32'(bus.OPB_timeout), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // all four requesting: strict rotation starting at master 0
    applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("rr_grant%0d", k), 32'(bus.OPB_MGrant), 32'(oh(k % 4)));
      checkOutput($sformatf("rr_owner%0d", k), 32'(bus.arb_owner),  32'(k % 4));
      applyStimulus(4'b1111, 4'b0000, oh(k % 4), 4'b0001);
      tick();
      checkOutput($sformatf("rr_drop%0d", k), 32'(bus.OPB_MGrant), 32'h0);
      applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000);
      tick();
      checkOutput($sformatf("rr_idle%0d", k), 32'(bus.OPB_MGrant), 32'h0);
    end

    // master 2 locks across three transfers while master 0 waits
    applyStimulus(4'b0101, 4'b0100, 4'b0000, 4'b0000);
    tick();
    checkOutput("lock_grant", 32'(bus.OPB_MGrant), 32'h4);
    checkOutput("lock_owner", 32'(bus.arb_owner),  32'h2);
    for (int x = 0; x < 2; x++) begin
      applyStimulus(4'b0101, 4'b0100, 4'b0100, 4'b0001);
      tick();
      checkOutput($sformatf("lock_busy%0d", x), 32'(bus.OPB_MGrant), 32'h0);
      applyStimulus(4'b0101, 4'b0100, 4'b0000, 4'b0000);
      tick();
      checkOutput($sformatf("lock_regrant%0d", x), 32'(bus.OPB_MGrant), 32'h4);
      checkOutput($sformatf("lock_reowner%0d", x), 32'(bus.arb_owner),  32'h2);
    end
    applyStimulus(4'b0101, 4'b0100, 4'b0100, 4'b0001);
    tick();
    checkOutput("lock_busy2", 32'(bus.OPB_MGrant), 32'h0);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("lock_release", 32'(bus.OPB_MGrant), 32'h0);
    tick();
    checkOutput("lock_m0_grant", 32'(bus.OPB_MGrant), 32'h1);
    checkOutput("lock_m0_owner", 32'(bus.arb_owner),  32'h0);

    // non-owner select reaches OPB_select but leaves the grant alone
    applyStimulus(4'b0001, 4'b0000, 4'b1000, 4'b0000);
    #1;
    checkOutput("nonowner_select", 32'(bus.OPB_select), 32'h1);
    tick();
    checkOutput("nonowner_grant",   32'(bus.OPB_MGrant),  32'h1);
    checkOutput("nonowner_timeout", 32'(bus.OPB_timeout), 32'h0);

    // unanswered select: one pulse on the 16th sampled cycle
    applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick();
    checkOutput("tout_busy", 32'(bus.OPB_MGrant), 32'h0);
    count_pulses(20, 0, pulses, first);
    checkOutput("tout_pulses",   32'(pulses), 32'd1);
    checkOutput("tout_position", 32'(first),  32'd15);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();

    // toutSup held suppresses the pulse
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("sup_grant", 32'(bus.OPB_MGrant), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b1000);
    tick();
    count_pulses(20, 0, pulses, first);
    checkOutput("sup_pulses", 32'(pulses), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();

    // ack on the would-be timeout cycle wins
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("ackwin_grant", 32'(bus.OPB_MGrant), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick();
    count_pulses(20, 15, pulses, first);
    checkOutput("ackwin_pulses", 32'(pulses), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();

    // asynchronous reset during BUSY while the timeout pulse is up
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("rstB_grant_pre", 32'(bus.OPB_MGrant), 32'h1);
    applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick();
    repeat (15) tick();
    checkOutput("rstB_pulse", 32'(bus.OPB_timeout), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstB_timeout", 32'(bus.OPB_timeout), 32'h0);
    checkOutput("rstB_owner",   32'(bus.arb_owner),   32'h3);
    checkOutput("rstB_grant",   32'(bus.OPB_MGrant),  32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b0;

    // parking on master 1
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("park_setup", 32'(bus.OPB_MGrant), 32'h2);
    applyStimulus(4'b0000, 4'b0000, 4'b0010, 4'b0000);
    tick();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    tick();
    checkOutput("park_grant", 32'(bus.OPB_MGrant), PARK ? 32'h2 : 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0010, 4'b0000);
    tick();
    checkOutput("park_select", 32'(bus.OPB_MGrant), 32'h0);
    count_pulses(16, 0, pulses, first);
    checkOutput("park_busy_watchdog", 32'(pulses), PARK ? 32'd1 : 32'd0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("park_exit", 32'(bus.OPB_MGrant), 32'h0);
    tick();
    checkOutput("park_regrant", 32'(bus.OPB_MGrant), PARK ? 32'h2 : 32'h0);
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checkOutput("park_rearb_grant", 32'(bus.OPB_MGrant), 32'h8);
    checkOutput("park_rearb_owner", 32'(bus.arb_owner),  32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/opb_master_rr_arbiter.md
# opb_master_rr_arbiter

Round-robin arbiter and bus watchdog for the OPB segment that carries the software-register slaves (simulink2ppc/ppc2simulink registers at 0x0100_xxxx). It shares that OPB between up to 8 masters: the PPC bridge, the DMA snapshot engine and debug masters. It issues one-hot grants, honours bus locking, ORs the master selects onto OPB_select, and asserts OPB_timeout when no slave answers a selected transfer.

## Interface
- NUM_MASTERS, 2: number of requesting masters, legal 2..8.
- TIMEOUT_CYCLES, 16: cycles of unanswered OPB_select before OPB_timeout; legal 4..255.
- OPB_Clk  in  1  bus clock; all logic is on its rising edge.
- OPB_Rst  in  1  reset, asynchronous, active-high.
- M_request  in  NUM_MASTERS  per-master bus request.
- M_busLock  in  NUM_MASTERS  per-master lock; keeps ownership across transfers.
- M_select  in  NUM_MASTERS  per-master select; only the owner may drive it.
- OPB_xferAck  in  1  slave transfer acknowledge (ORed slave Sl_xferAck).
- OPB_errAck  in  1  slave error acknowledge.
- OPB_retry  in  1  slave retry.
- OPB_toutSup  in  1  slave timeout suppress.
- OPB_MGrant  out  NUM_MASTERS  registered one-hot grant.
- OPB_select  out  1  OR of M_select (combinational).
- OPB_timeout  out  1  one-cycle bus-timeout pulse.
- arb_owner  out  3  index of current or last owner, for debug.

## Operation
- States: IDLE, GRANT, BUSY.
- IDLE:
  - Any M_request set: pick the winner as the first requester found scanning from last_owner+1 upward, mod NUM_MASTERS.
  - Load last_owner with the winner, set OPB_MGrant to its one-hot, go to GRANT.
  - No M_request set: stay in IDLE. OPB_MGrant = 0, except under parking (see Configuration).
- GRANT: grant held to the owner only.
  - M_select[owner]=1: go to BUSY and drop the grant.
  - Else M_request[owner]=0 and M_busLock[owner]=0: go to IDLE.
  - Otherwise stay in GRANT.
- BUSY: grant is 0; the owner runs transfers.
  - M_select[owner] falls and M_busLock[owner]=1: go to GRANT with the same owner. No re-arbitration and last_owner is unchanged.
  - M_select[owner] falls and M_busLock[owner]=0: go to IDLE.
- Watchdog (BUSY only):
  - The 8-bit counter increments each cycle that OPB_select=1 and none of xferAck, errAck, retry or toutSup is set.
  - Any of those four clears the counter. OPB_select=0 also clears it.
  - On the cycle the counter reaches TIMEOUT_CYCLES-1, OPB_timeout=1 for exactly one cycle and the counter clears.
- OPB_retry: no special action here. The owner drops select, and the arbiter then follows the normal BUSY exit. Fairness comes from the round-robin pointer.
- A select asserted by a non-owner is passed to OPB_select but never changes state. The bench checks for it as a protocol error.

## Timing
- Reset values:
  - state IDLE, last_owner = NUM_MASTERS-1 (master 0 wins first).
  - OPB_MGrant=0, OPB_timeout=0, counter=0, arb_owner=NUM_MASTERS-1.
- Reset asserted mid-transfer clears the grant and timeout immediately (asynchronous). The bench treats in-flight transfers as aborted.
- Grant latency: request sampled high at edge t gives OPB_MGrant high after edge t; 1 cycle from IDLE.
- Grant drop: M_select[owner] sampled high at edge t gives grant low after edge t.
- Back-to-back: the BUSY exit to IDLE costs 1 cycle, so a new grant appears 2 edges after select falls.
- Simultaneous requests resolve strictly by the round-robin pointer; there is no fixed priority.
- A response arriving on the same cycle the counter reaches TIMEOUT_CYCLES-1 wins: no timeout pulse is issued.
- OPB_select is combinational from M_select and adds zero latency.

## Configuration
- OPB_ARB_PARK_EN defined: in IDLE with no requests, OPB_MGrant = one-hot of last_owner.
  - A parked master asserting M_select goes straight to BUSY without requesting.
  - A request from any other master re-arbitrates normally. The park grant is replaced on the next edge.
- Undefined: OPB_MGrant = 0 in IDLE. Every transfer requires request then grant.

## Test plan
- Reset then M_request=0b0001: OPB_MGrant=0b0001 after 1 edge. Select high 3 cycles with xferAck: grant drops, state returns to IDLE, OPB_timeout stays 0.
- NUM_MASTERS=4, all requesting continuously, each doing one single-cycle transfer: grant order 0,1,2,3,0.
- Master 2 holds busLock over 3 transfers while master 0 requests: master 2 is re-granted each time. Master 0 is granted only after lock and select drop.
- TIMEOUT_CYCLES=16, select held with no ack: OPB_timeout is a single pulse 16 cycles after select rose. The same case with toutSup held produces no pulse.
- Async reset asserted in BUSY with grant pending: all outputs reach their reset values without a clock edge. The next request from master 0 is granted first.
- OPB_ARB_PARK_EN defined, master 1 last owner, no requests: OPB_MGrant=0b0010. Master 1 selects without requesting and enters BUSY. Undefined build: grant is 0 in the same case.
